user_rom_arbiter: RTL
=====================

// Module: user_rom_arbiter
// PURPOSE
// Shares the single OBI port of the user-domain ROM between NumMgr OBI managers, e.g. core data port and a
// boot/string streamer. Round-robin arbitration on the A channel; in-order routing of R-channel responses
// via an internal transaction-owner FIFO. Sits between the user-domain demux and user_rom.
// PARAMETERS
// ObiCfg     obi_pkg::ObiDefaultConfig  OBI widths (AddrWidth, DataWidth, IdWidth)
// obi_req_t  logic                      OBI request struct (req, a.{addr,we,be,wdata,aid})
// obi_rsp_t  logic                      OBI response struct (gnt, rvalid, r.{rdata,rid,err,r_optional})
// NumMgr     2                          number of managers, >=2
// MaxTrans   4                          max outstanding transactions, >= subordinate latency (ROM: 2)
// PORTS
// clk_i             in   1                  clock
// rst_i             in   1                  synchronous reset, active-high
// mgr_req_i         in   obi_req_t[NumMgr]  manager requests
// mgr_rsp_o         out  obi_rsp_t[NumMgr]  manager responses
// sbr_req_o         out  obi_req_t          request to ROM
// sbr_rsp_i         in   obi_rsp_t          response from ROM
// unexp_rsp_o       out  1                  sticky: rvalid received with no outstanding transaction
// BEHAVIOUR
// Reset (rst_i=1 at posedge): rr_ptr=0, lock=0, FIFO empty (count=0), unexp_rsp_o=0.
//   Combinational outputs are all-zero while no manager requests and no rvalid arrives.
// Arbitration, combinational, same cycle:
//   - Eligible: mgr_req_i[k].req && count<MaxTrans. Full FIFO blocks all grants, even if a pop occurs that cycle.
//   - Winner: first eligible index searched from rr_ptr upward, modulo NumMgr.
//   - lock=1 forces winner=locked_idx (OBI A-channel stability).
//   - sbr_req_o = mgr_req_i[winner]; sbr_req_o.req=0 if no eligible manager.
//   - mgr_rsp_o[winner].gnt = sbr_rsp_i.gnt; gnt=0 for all others.
// Handshake (sbr req && gnt):
//   - push winner index into FIFO; rr_ptr <= (winner+1)%NumMgr; lock <= 0.
// Req without gnt:
//   - lock<=1, locked_idx<=winner; rr_ptr holds.
// No handshake: rr_ptr holds.
// Response (sbr_rsp_i.rvalid):
//   - owner = FIFO head; pop.
//   - mgr_rsp_o[owner].rvalid=1 and .r=sbr_rsp_i.r (rdata, rid, err passed unchanged, incl. err on writes).
//   - All other managers rvalid=0; r fields are don't-care when rvalid=0, driven 0.
// Simultaneous push+pop: count unchanged; head advances, entry written at tail.
// rvalid while count==0: response dropped, unexp_rsp_o <= 1; cleared only by reset.
// Latency: zero added cycles both directions. ROM read = gnt at cycle N, rvalid at N+2.
// FIFO pointers wrap modulo MaxTrans; count width $clog2(MaxTrans+1).
// Reset mid-operation: outstanding entries discarded. Integration holds ROM and arbiter in reset together,
//   so no stale rvalid follows.
// STRUCTURE
// user_rom_arb_pkg: typedef mgr_idx_t = logic[$clog2(NumMgr)-1:0] (via parameterised macro/localparam),
//   function rr_pick(req_vec, ptr).
// Sub-module user_rom_arb_owner_fifo: depth MaxTrans, width $clog2(NumMgr), sync active-high reset,
//   push/pop/full/empty/head. Top keeps arbitration, lock and routing.
// TESTING
// 1. Single mgr0 read of addr 0x0 -> gnt cycle 0; mgr_rsp_o[0].rvalid cycle 2, rdata=32'h49502E54; mgr1 rvalid stays 0.
// 2. mgr0+mgr1 req every cycle, rr_ptr=0 -> grants 0,1,0,1. Responses routed in grant order, rid intact.
// 3. Stalled subordinate: gnt=0 for 3 cycles while mgr0 locked, mgr1 raises req -> winner stays mgr0, sbr a-fields stable; mgr0 gnt on cycle 4.
// 4. Subordinate gnt=1, rvalid withheld, MaxTrans=4 -> 4 grants, 5th blocked; first rvalid frees the slot on the next cycle.
// 5. mgr1 write to 0x4 -> mgr_rsp_o[1].rvalid with err=1 two cycles later.
// 6. Reset with 2 outstanding -> FIFO empty, rr_ptr=0. Injected rvalid with count==0 -> dropped, unexp_rsp_o=1 until reset.

Source files
------------

// File: rtl/user_rom_arb_pkg.sv
// Shared types and helpers for the user-domain ROM arbiter: OBI structs,
// manager-index sizing and the round-robin pick function.
package user_rom_arb_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 1;

  // Upper bound on managers the round-robin search can scan.
  localparam int unsigned MaxMgr  = 16;
  localparam int unsigned MaxMgrW = 4;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
  } rom_obi_a_t;

  typedef struct packed {
    logic       req;
    rom_obi_a_t a;
  } rom_obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    logic                 r_optional;
  } rom_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    rom_obi_r_t r;
  } rom_obi_rsp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req_vec at or after ptr, wrapping modulo num.
  function automatic int unsigned rr_pick(input logic [MaxMgr-1:0] req_vec,
                                          input int unsigned ptr,
                                          input int unsigned num);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxMgr; i++) begin
      idx = ptr + i;
      if (idx >= num) idx = idx - num;
      if (!found && (i < num) && req_vec[idx[MaxMgrW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/user_rom_arb_owner_fifo.sv
// In-order FIFO of granted manager indices; the head names the owner of the
// next R-channel response.
module user_rom_arb_owner_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/user_rom_arbiter.sv
// Round-robin arbiter sharing the user ROM OBI port between several managers;
// responses return to their issuers in grant order with no added latency.
module user_rom_arbiter
  import user_rom_arb_pkg::*;
#(
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 4,
  parameter type obi_req_t = rom_obi_req_t,
  parameter type obi_rsp_t = rom_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i,
  output logic     unexp_rsp_o
);

  localparam int unsigned IdxW = idx_width(NumMgr);
  typedef logic [IdxW-1:0] mgr_idx_t;

  logic [MaxMgr-1:0] elig;
  mgr_idx_t          winner;
  mgr_idx_t          rr_ptr;
  mgr_idx_t          locked_idx;
  mgr_idx_t          head;
  logic              lock;
  logic              sbr_valid;
  logic              handshake;
  logic              pop;
  logic              full;
  logic              empty;

  // A full owner FIFO blocks every grant, even in a cycle that also pops.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NumMgr; k++) elig[k] = mgr_req_i[k].req & ~full;
  end

  // An ungranted request stays selected so its A-channel remains stable.
  always_comb begin
    winner    = lock ? locked_idx : mgr_idx_t'(rr_pick(elig, 32'(rr_ptr), NumMgr));
    sbr_valid = lock ? (mgr_req_i[locked_idx].req & ~full) : (|elig);
  end

  assign handshake = sbr_valid & sbr_rsp_i.gnt;
  assign pop       = sbr_rsp_i.rvalid & ~empty;

  always_comb begin
    sbr_req_o = '0;
    for (int unsigned k = 0; k < NumMgr; k++) mgr_rsp_o[k] = '0;
    if (sbr_valid) begin
      sbr_req_o     = mgr_req_i[winner];
      sbr_req_o.req = 1'b1;
      mgr_rsp_o[winner].gnt = sbr_rsp_i.gnt;
    end
    if (pop) begin
      mgr_rsp_o[head].rvalid = 1'b1;
      mgr_rsp_o[head].r      = sbr_rsp_i.r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      lock        <= 1'b0;
      locked_idx  <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= (winner == mgr_idx_t'(NumMgr - 1)) ? '0 : winner + 1'b1;
        lock   <= 1'b0;
      end else if (sbr_valid) begin
        lock       <= 1'b1;
        locked_idx <= winner;
      end
      if (sbr_rsp_i.rvalid && empty) unexp_rsp_o <= 1'b1;
    end
  end

  user_rom_arb_owner_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_owner_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (handshake),
    .push_data (winner),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

endmodule
